// File: rtl/alu_sequencer.sv
// Control stage in front of the 16-bit logic unit: takes one operation per
// handshake, strobes the ALU, reads the stored result back and offers it downstream.
module alu_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OP_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid_i,
    output logic                op_ready_o,
    input  logic [OP_W-1:0]     opcode_i,
    input  logic [DATA_W-1:0]   operand_a_i,
    input  logic [DATA_W-1:0]   operand_b_i,
    output logic [DATA_W-1:0]   bus1_o,
    output logic [DATA_W-1:0]   bus2_o,
    output logic                alu_pass_o,
    output logic                alu_pass_high_o,
    output logic                alu_push_o,
    output logic                alu_push_high_o,
    output logic                alu_add_o,
    output logic                alu_sub_o,
    output logic                alu_inc_o,
    output logic                alu_dec_o,
    output logic                alu_mul_o,
    output logic                alu_shr_o,
    output logic                alu_shl_o,
    output logic                alu_band_o,
    output logic                alu_bor_o,
    output logic                alu_bxor_o,
    output logic                alu_bnegate_o,
    input  logic [DATA_W-1:0]   bus3_i,
    input  logic [DATA_W-1:0]   bus4_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [2*DATA_W-1:0] res_data_o,
    output logic                res_err_o,
    output logic [15:0]         op_count_o
);

    localparam logic [OP_W-1:0] OpPass = OP_W'(0);
    localparam logic [OP_W-1:0] OpLast = OP_W'(11);

    typedef enum logic [1:0] {StIdle, StExec, StFetch, StDone} state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     opcode_q, opcode_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] res_data_q, res_data_d;
    logic                res_err_q, res_err_d;
    logic [15:0]         count_q, count_d;

    // Operand buses always reflect the latched request; reset clears them to zero.
    assign bus1_o      = a_q;
    assign bus2_o      = b_q;
    assign res_data_o  = res_data_q;
    assign res_err_o   = res_err_q;
    assign op_count_o  = count_q;

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            opcode_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            count_q    <= count_d;
        end
    end

    // Next-state, handshakes and ALU strobes.
    always_comb begin
        state_d         = state_q;
        opcode_d        = opcode_q;
        a_d             = a_q;
        b_d             = b_q;
        res_data_d      = res_data_q;
        res_err_d       = res_err_q;
        count_d         = count_q;
        op_ready_o      = 1'b0;
        res_valid_o     = 1'b0;
        alu_pass_o      = 1'b0;
        alu_pass_high_o = 1'b0;
        alu_push_o      = 1'b0;
        alu_push_high_o = 1'b0;
        alu_add_o       = 1'b0;
        alu_sub_o       = 1'b0;
        alu_inc_o       = 1'b0;
        alu_dec_o       = 1'b0;
        alu_mul_o       = 1'b0;
        alu_shr_o       = 1'b0;
        alu_shl_o       = 1'b0;
        alu_band_o      = 1'b0;
        alu_bor_o       = 1'b0;
        alu_bxor_o      = 1'b0;
        alu_bnegate_o   = 1'b0;
        case (state_q)
            StIdle: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
                    opcode_d = opcode_i;
                    a_d      = operand_a_i;
                    b_d      = operand_b_i;
                    if (opcode_i > OpLast) begin
                        // Illegal opcode never touches the ALU.
                        res_err_d  = 1'b1;
                        res_data_d = '0;
                        state_d    = StDone;
                    end else if (opcode_i == OpPass) begin
                        res_err_d = 1'b0;
                        state_d   = StFetch;
                    end else begin
                        res_err_d = 1'b0;
                        state_d   = StExec;
                    end
                end
            end
            StExec: begin
                case (opcode_q)
                    OP_W'(1):  alu_add_o     = 1'b1;
                    OP_W'(2):  alu_sub_o     = 1'b1;
                    OP_W'(3):  alu_inc_o     = 1'b1;
                    OP_W'(4):  alu_dec_o     = 1'b1;
                    OP_W'(5):  alu_mul_o     = 1'b1;
                    OP_W'(6):  alu_shr_o     = 1'b1;
                    OP_W'(7):  alu_shl_o     = 1'b1;
                    OP_W'(8):  alu_band_o    = 1'b1;
                    OP_W'(9):  alu_bor_o     = 1'b1;
                    OP_W'(10): alu_bxor_o    = 1'b1;
                    OP_W'(11): alu_bnegate_o = 1'b1;
                    default:   ;
                endcase
                state_d = StFetch;
            end
            StFetch: begin
                // Pass routes the operands straight through; otherwise read the store.
                if (opcode_q == OpPass) begin
                    alu_pass_o      = 1'b1;
                    alu_pass_high_o = 1'b1;
                end else begin
                    alu_push_o      = 1'b1;
                    alu_push_high_o = 1'b1;
                end
                res_data_d = {bus4_i, bus3_i};
                state_d    = StDone;
            end
            StDone: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    count_d = count_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU attached to its buses.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  opcode;
    logic [15:0] operand_a, operand_b;
    logic [15:0] bus1, bus2, bus3, bus4;
    logic        alu_pass, alu_pass_high, alu_push, alu_push_high;
    logic        alu_add, alu_sub, alu_inc, alu_dec, alu_mul, alu_shr, alu_shl;
    logic        alu_band, alu_bor, alu_bxor, alu_bnegate;
    logic        res_valid, res_ready, res_err;
    logic [31:0] res_data;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;
    int n_op = 0, n_push = 0, n_pass = 0;
    logic [15:0] exp_count = 16'd0;
    logic [31:0] store = 32'd0;
    logic [15:0] junk3 = 16'h5a5a, junk4 = 16'ha5a5;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op_valid_i     (op_valid),
        .op_ready_o     (op_ready),
        .opcode_i       (opcode),
        .operand_a_i    (operand_a),
        .operand_b_i    (operand_b),
        .bus1_o         (bus1),
        .bus2_o         (bus2),
        .alu_pass_o     (alu_pass),
        .alu_pass_high_o(alu_pass_high),
        .alu_push_o     (alu_push),
        .alu_push_high_o(alu_push_high),
        .alu_add_o      (alu_add),
        .alu_sub_o      (alu_sub),
        .alu_inc_o      (alu_inc),
        .alu_dec_o      (alu_dec),
        .alu_mul_o      (alu_mul),
        .alu_shr_o      (alu_shr),
        .alu_shl_o      (alu_shl),
        .alu_band_o     (alu_band),
        .alu_bor_o      (alu_bor),
        .alu_bxor_o     (alu_bxor),
        .alu_bnegate_o  (alu_bnegate),
        .bus3_i         (bus3),
        .bus4_i         (bus4),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_data_o     (res_data),
        .res_err_o      (res_err),
        .op_count_o     (op_count)
    );

    wire [10:0] op_strobes = {alu_add, alu_sub, alu_inc, alu_dec, alu_mul, alu_shr, alu_shl,
                              alu_band, alu_bor, alu_bxor, alu_bnegate};
    wire [14:0] all_strobes = {op_strobes, alu_pass, alu_pass_high, alu_push, alu_push_high};

    // Behavioural ALU: store updates on a strobe, buses 3/4 float to garbage when not driven.
    always @(posedge clk) begin
        junk3 <= 16'($urandom);
        junk4 <= 16'($urandom);
        if (alu_add)          store <= {16'd0, bus1} + {16'd0, bus2};
        else if (alu_sub)     store <= {16'd0, bus1} - {16'd0, bus2};
        else if (alu_inc)     store <= {16'd0, bus1} + 32'd1;
        else if (alu_dec)     store <= {16'd0, bus1} - 32'd1;
        else if (alu_mul)     store <= {16'd0, bus1} * {16'd0, bus2};
        else if (alu_shr)     store <= {16'd0, bus1} >> 1;
        else if (alu_shl)     store <= {16'd0, bus1} << 1;
        else if (alu_band)    store <= {16'd0, bus1 & bus2};
        else if (alu_bor)     store <= {16'd0, bus1 | bus2};
        else if (alu_bxor)    store <= {16'd0, bus1 ^ bus2};
        else if (alu_bnegate) store <= {16'd0, ~bus1};
    end
    assign bus3 = alu_push ? store[15:0] : (alu_pass ? bus1 : junk3);
    assign bus4 = alu_push_high ? store[31:16] : (alu_pass_high ? bus2 : junk4);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: result of an opcode as seen by the consumer.
    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [31:0] wa, wb;
        wa = {16'd0, a};
        wb = {16'd0, b};
        case (op)
            4'd0:    return {b, a};
            4'd1:    return wa + wb;
            4'd2:    return wa - wb;
            4'd3:    return wa + 32'd1;
            4'd4:    return wa - 32'd1;
            4'd5:    return wa * wb;
            4'd6:    return wa >> 1;
            4'd7:    return wa << 1;
            4'd8:    return wa & wb;
            4'd9:    return wa | wb;
            4'd10:   return wa ^ wb;
            4'd11:   return {16'd0, ~a};
            default: return 32'd0;
        endcase
    endfunction

    // Strobe rules checked every cycle; also counts strobe cycles per transaction.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot_op", 32'($countones(op_strobes) <= 1), 32'd1);
            chk("op_vs_fetch", 32'((|op_strobes) && (alu_push | alu_pass)), 32'd0);
            chk("push_pair", 32'(alu_push), 32'(alu_push_high));
            chk("pass_pair", 32'(alu_pass), 32'(alu_pass_high));
            if (op_ready || res_valid) chk("idle_strobes", 32'(all_strobes), 32'd0);
            if (|op_strobes) n_op++;
            if (alu_push) n_push++;
            if (alu_pass) n_pass++;
        end
    end

    // Issue one op at a negedge, follow it to DONE, hold res_ready low, then consume.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold);
        logic [31:0] exp_d;
        int exp_lat, lat;
        bit seen, is_alu;
        exp_d   = ref_res(op, a, b);
        is_alu  = (op >= 4'd1 && op <= 4'd11);
        exp_lat = (op > 4'd11) ? 1 : (op == 4'd0) ? 2 : 3;
        n_op = 0; n_push = 0; n_pass = 0;
        chk("op_ready_idle", 32'(op_ready), 32'd1);
        op_valid = 1'b1; opcode = op; operand_a = a; operand_b = b;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && is_alu) chk("bus12_exec", {bus2, bus1}, {b, a});
            seen = res_valid;
            if (seen) begin
                op_valid = 1'b0;
            end else begin
                // Traffic while busy must be ignored.
                op_valid  = 1'($urandom);
                opcode    = 4'($urandom);
                operand_a = 16'($urandom);
                operand_b = 16'($urandom);
            end
        end
        op_valid = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("res_data", res_data, exp_d);
        chk("res_err", 32'(res_err), 32'(op > 4'd11));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", res_data, exp_d);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        chk("valid_cleared", 32'(res_valid), 32'd0);
        chk("op_count", 32'(op_count), 32'(exp_count));
        chk("n_op_strobe", 32'(n_op), 32'(is_alu));
        chk("n_push", 32'(n_push), 32'(is_alu));
        chk("n_pass", 32'(n_pass), 32'(op == 4'd0));
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
        res_ready = 1'b0;
        #1;
        chk("rst_strobes", 32'(all_strobes), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_err", 32'(res_err), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_bus", {bus2, bus1}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(op_ready), 32'd1);

        run_op(4'd1, 16'h0003, 16'h0004, 0);
        run_op(4'd5, 16'hFFFF, 16'hFFFF, 1);
        run_op(4'd2, 16'h0001, 16'h0002, 0);
        run_op(4'd4, 16'h0000, 16'h1111, 0);
        run_op(4'd0, 16'h1234, 16'hABCD, 2);
        run_op(4'd15, 16'h5555, 16'h6666, 5);
        for (int k = 0; k < 40; k++)
            run_op(4'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));

        // Reset while EXEC is active.
        op_valid = 1'b1; opcode = 4'd1; operand_a = 16'h0010; operand_b = 16'h0020;
        @(negedge clk);
        op_valid = 1'b0;
        chk("exec_add", 32'(alu_add), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_strobes", 32'(all_strobes), 32'd0);
        chk("abort_valid", 32'(res_valid), 32'd0);
        chk("abort_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 16'd0;
        @(negedge clk);
        chk("abort_idle", 32'(op_ready), 32'd1);
        run_op(4'd3, 16'h7FFF, 16'h0000, 0);

        // Preload the counter to its top value, then wrap it with one more op.
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        exp_count = 16'hFFFF;
        @(negedge clk);
        chk("count_preload", 32'(op_count), 32'h0000FFFF);
        run_op(4'd10, 16'h00FF, 16'h0F0F, 0);
        chk("count_wrap", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
